// File: rtl/mundo_pkg.sv
// Shared definitions for the wall-following robot world model: headings,
// FSM encoding and the per-heading grid step.
package mundo_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  // Two's-complement unit step, each field in {-1, 0, +1}
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } offs_t;

  function automatic offs_t dir_offset(input logic [1:0] d);
    offs_t o;
    o = '{dx: 2'b00, dy: 2'b00};
    case (d)
      DIR_N:   o.dy = 2'b01;
      DIR_E:   o.dx = 2'b01;
      DIR_S:   o.dy = 2'b11;
      default: o.dx = 2'b11;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mundo_map.sv
// Wall bitmap (1 = wall) with async clear, gated write port and two
// combinational lookups; anything off the grid reads as a wall.
module mundo_map #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int CW = 5,
  parameter int AW = $clog2(W*H)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic                 wdata,
  input  logic signed [CW-1:0] ax,
  input  logic signed [CW-1:0] ay,
  input  logic signed [CW-1:0] lx,
  input  logic signed [CW-1:0] ly,
  output logic                 wall_ahead,
  output logic                 wall_left
);

  logic [W*H-1:0] bits;

  function automatic logic lookup(input logic [W*H-1:0] m,
                                  input logic signed [CW-1:0] x,
                                  input logic signed [CW-1:0] y);
    logic [AW-1:0] idx;
    if (x[CW-1] || y[CW-1] || x >= $signed(CW'(W)) || y >= $signed(CW'(H)))
      return 1'b1;
    idx = AW'(y) * AW'(W) + AW'(x);
    return m[idx];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          bits       <= '0;
    else if (we && en)  bits[addr] <= wdata;
  end

  always_comb begin
    wall_ahead = lookup(bits, ax, ay);
    wall_left  = lookup(bits, lx, ly);
  end

endmodule

// File: rtl/mundo_robo.sv
// Cycle-based world for the wall-following controller; optional bump
// counter port enabled by MUNDO_COLLISION_CNT_EN.
module mundo_robo import mundo_pkg::*; #(
  parameter int W         = 8,
  parameter int H         = 8,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int START_DIR = 0,
  parameter int GOAL_X    = W-1,
  parameter int GOAL_Y    = H-1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      map_we,
  input  logic [$clog2(W*H)-1:0]    map_addr,
  input  logic                      map_wdata,
  input  logic                      avancar,
  input  logic                      girar,
  output logic                      head,
  output logic                      left,
  output logic [$clog2(W)-1:0]      pos_x,
  output logic [$clog2(H)-1:0]      pos_y,
  output logic [1:0]                dir,
  output logic                      running,
  output logic                      done,
  output logic                      fault,
  output logic                      bump,
  output logic [15:0]               step_count
`ifdef MUNDO_COLLISION_CNT_EN
  , output logic [7:0]              collisions
`endif
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = ((XW > YW) ? XW : YW) + 2;

  state_t state, state_n;
  logic [XW-1:0] px_n;
  logic [YW-1:0] py_n;
  logic [1:0]    d_n;
  logic          head_n, left_n, done_n, fault_n, bump_n, goal_hit;
  logic [15:0]   steps_n, steps_inc;
  offs_t         fo, lo;
  logic signed [CW-1:0] nx, ny, ax, ay, lx, ly;
  logic          wall_ahead, wall_left;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if ((avancar && girar) || goal_hit) state_n = S_HALT;
      S_HALT:  if (start) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb running = (state == S_RUN);

  // During RUN the map is frozen, so the registered head sensor is exactly
  // the wall status of the cell ahead of the current pose.
  always_comb begin
    px_n      = pos_x;
    py_n      = pos_y;
    d_n       = dir;
    done_n    = done;
    fault_n   = fault;
    bump_n    = 1'b0;
    goal_hit  = 1'b0;
    steps_inc = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
    steps_n   = step_count;
    case (state)
      S_IDLE: begin
        px_n = XW'(START_X);
        py_n = YW'(START_Y);
        d_n  = 2'(START_DIR);
      end
      S_RUN: begin
        if (avancar && girar) begin
          fault_n = 1'b1;
        end else if (avancar) begin
          if (head) begin
            bump_n = 1'b1;
          end else begin
            case (dir)
              DIR_N:   py_n = pos_y + 1'b1;
              DIR_E:   px_n = pos_x + 1'b1;
              DIR_S:   py_n = pos_y - 1'b1;
              default: px_n = pos_x - 1'b1;
            endcase
            steps_n  = steps_inc;
            goal_hit = (px_n == XW'(GOAL_X)) && (py_n == YW'(GOAL_Y));
            done_n   = goal_hit;
          end
        end else if (girar) begin
          d_n     = dir + 2'd1;
          steps_n = steps_inc;
        end
      end
      S_HALT: begin
        if (start) begin
          px_n    = XW'(START_X);
          py_n    = YW'(START_Y);
          d_n     = 2'(START_DIR);
          done_n  = 1'b0;
          fault_n = 1'b0;
          steps_n = '0;
        end
      end
      default: ;
    endcase
  end

  // Sensors are looked up against the pose that will be registered this edge
  always_comb begin
    fo = dir_offset(d_n);
    lo = dir_offset(d_n + 2'd3);
    nx = $signed(CW'(px_n));
    ny = $signed(CW'(py_n));
    ax = nx + $signed({{(CW-2){fo.dx[1]}}, fo.dx});
    ay = ny + $signed({{(CW-2){fo.dy[1]}}, fo.dy});
    lx = nx + $signed({{(CW-2){lo.dx[1]}}, lo.dx});
    ly = ny + $signed({{(CW-2){lo.dy[1]}}, lo.dy});
    head_n = (state_n != S_IDLE) && wall_ahead;
    left_n = (state_n != S_IDLE) && wall_left;
  end

  mundo_map #(.W(W), .H(H), .CW(CW)) u_map (
    .clock      (clock),
    .reset      (reset),
    .en         (state == S_IDLE),
    .we         (map_we),
    .addr       (map_addr),
    .wdata      (map_wdata),
    .ax         (ax),
    .ay         (ay),
    .lx         (lx),
    .ly         (ly),
    .wall_ahead (wall_ahead),
    .wall_left  (wall_left)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_x      <= XW'(START_X);
      pos_y      <= YW'(START_Y);
      dir        <= 2'(START_DIR);
      head       <= 1'b0;
      left       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      bump       <= 1'b0;
      step_count <= '0;
    end else begin
      pos_x      <= px_n;
      pos_y      <= py_n;
      dir        <= d_n;
      head       <= head_n;
      left       <= left_n;
      done       <= done_n;
      fault      <= fault_n;
      bump       <= bump_n;
      step_count <= steps_n;
    end
  end

`ifdef MUNDO_COLLISION_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                collisions <= '0;
    else if (state == S_HALT && start)        collisions <= '0;
    else if (bump_n && collisions != 8'hFF)   collisions <= collisions + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mundo_robo.sv
// Directed bench for mundo_robo on the default 8x8 grid, start (0,0,N),
// goal (7,7); expected values are hand-derived per step.
module tb_mundo_robo;

  logic        clock = 1'b0;
  logic        reset, start, map_we, map_wdata, avancar, girar;
  logic [5:0]  map_addr;
  logic        head, left, running, done, fault, bump;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic [15:0] step_count;
`ifdef MUNDO_COLLISION_CNT_EN
  logic [7:0]  collisions;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mundo_robo dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .map_we     (map_we),
    .map_addr   (map_addr),
    .map_wdata  (map_wdata),
    .avancar    (avancar),
    .girar      (girar),
    .head       (head),
    .left       (left),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .running    (running),
    .done       (done),
    .fault      (fault),
    .bump       (bump),
    .step_count (step_count)
`ifdef MUNDO_COLLISION_CNT_EN
    , .collisions (collisions)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic a, input logic g);
    avancar = a;
    girar   = g;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 0; map_we = 0; map_wdata = 0; map_addr = '0;
    avancar = 0; girar = 0;
    tick();
    chk("rst_x", pos_x, 0);   chk("rst_y", pos_y, 0);   chk("rst_dir", dir, 0);
    chk("rst_head", head, 0); chk("rst_left", left, 0); chk("rst_run", running, 0);
    chk("rst_done", done, 0); chk("rst_fault", fault, 0); chk("rst_bump", bump, 0);
    chk("rst_steps", step_count, 0);
    reset = 1'b0;
    tick();

    // Empty map: walk north along the west boundary
    start = 1; tick(); start = 0;
    chk("a_run", running, 1); chk("a_head0", head, 0); chk("a_left0", left, 1);
    for (int i = 1; i <= 7; i++) begin
      cmd(1, 0);
      chk("a_y", pos_y, i); chk("a_left", left, 1); chk("a_head", head, (i == 7));
    end
    chk("a_steps", step_count, 7);

    for (int i = 1; i <= 2; i++) begin
      cmd(1, 0);
      chk("b_bump", bump, 1); chk("b_y", pos_y, 7); chk("b_steps", step_count, 7);
`ifdef MUNDO_COLLISION_CNT_EN
      chk("b_coll", collisions, i);
`endif
    end
    cmd(0, 0);
    chk("b_bump_clr", bump, 0);

    for (int i = 1; i <= 4; i++) begin
      cmd(0, 1);
      chk("c_dir", dir, i % 4); chk("c_steps", step_count, 7 + i);
      if (i == 3) begin
        chk("c_headW", head, 1); chk("c_leftW", left, 0);
      end
    end

    // Illegal command halts with a fault; start returns to IDLE
    cmd(1, 1);
    chk("d_fault", fault, 1); chk("d_run", running, 0); chk("d_y", pos_y, 7);
    chk("d_steps", step_count, 11);
    cmd(0, 1);
    chk("d_frz_dir", dir, 0); chk("d_frz_steps", step_count, 11);
    start = 1; cmd(0, 0); start = 0;
    chk("d_idle_y", pos_y, 0); chk("d_idle_fault", fault, 0);
    chk("d_idle_steps", step_count, 0); chk("d_idle_head", head, 0);
    chk("d_idle_run", running, 0);
`ifdef MUNDO_COLLISION_CNT_EN
    chk("d_coll_clr", collisions, 0);
`endif

    // Wall at (0,1) written in IDLE; write to (0,2) during RUN is dropped
    map_we = 1; map_addr = 6'd8; map_wdata = 1; cmd(0, 0); map_we = 0;
    chk("e_idle_head", head, 0);
    start = 1; cmd(0, 0); start = 0;
    chk("e_run", running, 1); chk("e_head", head, 1); chk("e_left", left, 1);
    map_we = 1; map_addr = 6'd16; map_wdata = 1; cmd(0, 0); map_we = 0;
    cmd(1, 0);
    chk("e_bump", bump, 1); chk("e_y", pos_y, 0); chk("e_steps0", step_count, 0);
    cmd(0, 1);
    chk("e_dirE", dir, 1); chk("e_leftE", left, 1); chk("e_headE", head, 0);
    cmd(1, 0);
    chk("e_x1", pos_x, 1);
    cmd(0, 1); cmd(0, 1); cmd(0, 1);
    chk("e_dirN", dir, 0); chk("e_steps5", step_count, 5);
    cmd(1, 0);
    chk("e_left11", left, 1);
    cmd(1, 0);
    chk("e_left12", left, 0); chk("e_steps7", step_count, 7);

    // Drive to the goal
    for (int i = 0; i < 5; i++) cmd(1, 0);
    chk("f_y7", pos_y, 7); chk("f_head", head, 1); chk("f_steps12", step_count, 12);
    cmd(0, 1);
    chk("f_dirE", dir, 1);
    for (int i = 0; i < 5; i++) cmd(1, 0);
    chk("f_x6", pos_x, 6); chk("f_done0", done, 0); chk("f_run1", running, 1);
    cmd(1, 0);
    chk("f_x7", pos_x, 7); chk("f_done", done, 1); chk("f_run0", running, 0);
    chk("f_steps19", step_count, 19);
    cmd(1, 0);
    chk("f_frz_x", pos_x, 7); chk("f_frz_bump", bump, 0); chk("f_frz_steps", step_count, 19);

    // New run keeps the map, then an async reset mid-RUN clears everything
    start = 1; cmd(0, 0); cmd(0, 0); start = 0;
    chk("g_run", running, 1); chk("g_head_kept", head, 1); chk("g_done", done, 0);
    cmd(0, 1);
    chk("g_dir", dir, 1); chk("g_steps", step_count, 1); chk("g_left", left, 1);
    #3 reset = 1'b1;
    #1;
    chk("g_rst_x", pos_x, 0); chk("g_rst_dir", dir, 0); chk("g_rst_run", running, 0);
    chk("g_rst_steps", step_count, 0); chk("g_rst_head", head, 0); chk("g_rst_left", left, 0);
    #1 reset = 1'b0;
    start = 1; cmd(0, 0); start = 0;
    chk("g_map_clr_head", head, 0); chk("g_map_clr_left", left, 1); chk("g_run2", running, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
